// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter and its wait counter.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LD  = 1'b1
    } port_sel_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with a registered zero flag; times the ACCESS dwell.
module sram_wait_counter
    import sram_arb_pkg::*;
#(
    parameter int unsigned W = WAIT_CNT_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;
    logic         zero_q, zero_d;

    // Next count: load wins over decrement; zero flag tracks the new value.
    always_comb begin
        count_d = count_q;
        zero_d  = zero_q;
        if (load_i) begin
            count_d = load_val_i;
            zero_d  = (load_val_i == W'(0));
        end else if (dec_i && !zero_q) begin
            count_d = count_q - W'(1);
            zero_d  = (count_q == W'(1));
        end
    end

    // Counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (CPU / host loader) multi-cycle SRAM access controller.
// Build option: define SRAM_ARB_RR_EN for round-robin tie-breaking;
// otherwise the CPU wins every tie (fixed priority).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W,
    parameter int unsigned WAIT   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_drive,
    input  logic [DATA_W-1:0] Data_from_SRAM
);

    arb_state_e        state_q, state_d;
    port_sel_e         grant_q, grant_d, win;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
    logic              cpu_ack_q, cpu_ack_d, ld_ack_q, ld_ack_d;
    logic              ce_q, ce_d, oe_q, oe_d, wen_q, wen_d, drive_q, drive_d;
    logic              cnt_load, cnt_dec, cnt_zero;
`ifdef SRAM_ARB_RR_EN
    port_sel_e         last_q, last_d;
`endif

    // Tie-break between simultaneous requests.
    always_comb begin
        win = PORT_CPU;
`ifdef SRAM_ARB_RR_EN
        if (cpu_req && ld_req) begin
            win = (last_q == PORT_LD) ? PORT_CPU : PORT_LD;
        end else if (!cpu_req) begin
            win = PORT_LD;
        end
`else
        if (!cpu_req) begin
            win = PORT_LD;
        end
`endif
    end

    // Next state, transaction latch and registered strobe decode.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef SRAM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || ld_req) begin
                    grant_d = win;
                    we_d    = (win == PORT_CPU) ? cpu_we    : ld_we;
                    addr_d  = (win == PORT_CPU) ? cpu_addr  : ld_addr;
                    wdata_d = (win == PORT_CPU) ? cpu_wdata : ld_wdata;
                    state_d = SETUP;
`ifdef SRAM_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            SETUP: begin
                cnt_load = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (cnt_zero) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (grant_q == PORT_CPU) cpu_rdata_d = Data_from_SRAM;
                        else                     ld_rdata_d  = Data_from_SRAM;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ce_d      = (state_d != IDLE);
        oe_d      = !((state_d == ACCESS) && !we_d);
        wen_d     = !((state_d == ACCESS) && we_d);
        drive_d   = ((state_d == SETUP) || (state_d == ACCESS)) && we_d;
        cpu_ack_d = (state_d == DONE) && (grant_d == PORT_CPU);
        ld_ack_d  = (state_d == DONE) && (grant_d == PORT_LD);
        ce_d      = !ce_d;
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            grant_q     <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            wen_q       <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            wen_q       <= wen_d;
            drive_q     <= drive_d;
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Last-grant flag; starts at loader so the CPU wins the first tie.
    always_ff @(posedge Clk) begin
        if (Reset) last_q <= PORT_LD;
        else       last_q <= last_d;
    end
`endif

    sram_wait_counter #(
        .W (WAIT_CNT_W)
    ) u_wait_cnt (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (cnt_load),
        .load_val_i (WAIT_CNT_W'(WAIT - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign cpu_ack      = cpu_ack_q;
    assign ld_ack       = ld_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign ld_rdata     = ld_rdata_q;
    assign Mem_CE       = ce_q;
    assign Mem_UB       = 1'b0;
    assign Mem_LB       = 1'b0;
    assign Mem_OE       = oe_q;
    assign Mem_WE       = wen_q;
    assign Mem_ADDR     = addr_q;
    assign Data_to_SRAM = wdata_q;
    assign Data_drive   = drive_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (WAIT=2 main instance,
// plus WAIT=1 and WAIT=15 instances for latency/dwell checks).
module tb_sram_arbiter;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [19:0] cpu_addr, ld_addr;
    logic [15:0] cpu_wdata, ld_wdata;
    logic        cpu_ack, ld_ack;
    logic [15:0] cpu_rdata, ld_rdata;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_drive;
    logic [19:0] Mem_ADDR;
    logic [15:0] Data_to_SRAM, mem_dout;
    logic [15:0] sram [256];

    // auxiliary instances: read-only CPU port, loader tied off
    logic        a1_req, a15_req, tie0;
    logic [19:0] tie_addr;
    logic [15:0] tie_data, aux_din;
    logic        a1_ack, a1_ldack, a1_ce, a1_ub, a1_lb, a1_oe, a1_we, a1_drv;
    logic        a15_ack, a15_ldack, a15_ce, a15_ub, a15_lb, a15_oe, a15_we, a15_drv;
    logic [15:0] a1_rdata, a1_ldrdata, a1_dout, a15_rdata, a15_ldrdata, a15_dout;
    logic [19:0] a1_maddr, a15_maddr;

    int errors = 0;
    int checks = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_drive(Data_drive),
        .Data_from_SRAM(mem_dout)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(a1_req), .cpu_we(tie0), .cpu_addr(tie_addr), .cpu_wdata(tie_data),
        .cpu_ack(a1_ack), .cpu_rdata(a1_rdata),
        .ld_req(tie0), .ld_we(tie0), .ld_addr(tie_addr), .ld_wdata(tie_data),
        .ld_ack(a1_ldack), .ld_rdata(a1_ldrdata),
        .Mem_CE(a1_ce), .Mem_UB(a1_ub), .Mem_LB(a1_lb), .Mem_OE(a1_oe), .Mem_WE(a1_we),
        .Mem_ADDR(a1_maddr), .Data_to_SRAM(a1_dout), .Data_drive(a1_drv),
        .Data_from_SRAM(aux_din)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT(15)) dut_w15 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(a15_req), .cpu_we(tie0), .cpu_addr(tie_addr), .cpu_wdata(tie_data),
        .cpu_ack(a15_ack), .cpu_rdata(a15_rdata),
        .ld_req(tie0), .ld_we(tie0), .ld_addr(tie_addr), .ld_wdata(tie_data),
        .ld_ack(a15_ldack), .ld_rdata(a15_ldrdata),
        .Mem_CE(a15_ce), .Mem_UB(a15_ub), .Mem_LB(a15_lb), .Mem_OE(a15_oe), .Mem_WE(a15_we),
        .Mem_ADDR(a15_maddr), .Data_to_SRAM(a15_dout), .Data_drive(a15_drv),
        .Data_from_SRAM(aux_din)
    );

    // SRAM model: 0x00123 reads back BEEF, other words come from a small array
    always_comb begin
        mem_dout = 16'h0000;
        if (!Mem_CE && !Mem_OE)
            mem_dout = (Mem_ADDR == 20'h00123) ? 16'hBEEF : sram[Mem_ADDR[7:0]];
    end

    always @(posedge Clk) begin
        if (!Mem_CE && !Mem_WE) sram[Mem_ADDR[7:0]] <= Data_to_SRAM;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Run one transaction on a port and measure it; the request drops at ack.
    task automatic run_xact(input bit port, input bit we, input logic [19:0] addr,
                            input logic [15:0] wd, output int lat, output int oe_lo,
                            output int we_lo, output int drv, output logic [15:0] dout,
                            output logic [19:0] ack_addr, output bit got);
        lat = 0; oe_lo = 0; we_lo = 0; drv = 0; dout = '0; ack_addr = '0; got = 1'b0;
        if (port) begin ld_we = we; ld_addr = addr; ld_wdata = wd; ld_req = 1'b1; end
        else begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; end
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            if (!Mem_OE) oe_lo++;
            if (!Mem_WE) begin we_lo++; dout = Data_to_SRAM; end
            if (Data_drive) drv++;
            if ((port && ld_ack) || (!port && cpu_ack)) begin
                got = 1'b1;
                ack_addr = Mem_ADDR;
                break;
            end
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        Reset = 1'b1;
        tick();
        checks++; if (cpu_ack !== 1'b0 || ld_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b/%b expected 0/0", cpu_ack, ld_ack); end
        checks++; if (cpu_rdata !== 16'h0 || ld_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, ld_rdata); end
        checks++; if ({Mem_CE, Mem_OE, Mem_WE} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got CE/OE/WE=%b expected 111", {Mem_CE, Mem_OE, Mem_WE}); end
        checks++; if ({Mem_UB, Mem_LB, Data_drive} !== 3'b000) begin errors++; $display("FAIL reset_ub_lb_drive: got %b expected 000", {Mem_UB, Mem_LB, Data_drive}); end
        checks++; if (Mem_ADDR !== 20'h0 || Data_to_SRAM !== 16'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", Mem_ADDR, Data_to_SRAM); end
        Reset = 1'b0;
        tick();
        checks++; if (Mem_CE !== 1'b1 || cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_idle: got CE=%b ack=%b expected 1/0", Mem_CE, cpu_ack); end
    endtask

    task automatic test_cpu_read();
        int lat, oe_lo, we_lo, drv;
        logic [15:0] dout;
        logic [19:0] aa;
        bit got;
        run_xact(1'b0, 1'b0, 20'h00123, 16'h0, lat, oe_lo, we_lo, drv, dout, aa, got);
        checks++; if (!got || lat !== 4) begin errors++; $display("FAIL cpu_read_latency: got %0d (ack=%b) expected 4", lat, got); end
        checks++; if (oe_lo !== 2 || we_lo !== 0) begin errors++; $display("FAIL cpu_read_oe: got OE low %0d WE low %0d expected 2/0", oe_lo, we_lo); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data: got %h expected BEEF", cpu_rdata); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_pulse: got %b expected 0", cpu_ack); end
    endtask

    task automatic test_ld_write();
        int lat, oe_lo, we_lo, drv;
        logic [15:0] dout;
        logic [19:0] aa;
        bit got;
        run_xact(1'b1, 1'b1, 20'h00040, 16'h1234, lat, oe_lo, we_lo, drv, dout, aa, got);
        checks++; if (!got || lat !== 4) begin errors++; $display("FAIL ld_write_latency: got %0d (ack=%b) expected 4", lat, got); end
        checks++; if (we_lo !== 2 || oe_lo !== 0) begin errors++; $display("FAIL ld_write_we: got WE low %0d OE low %0d expected 2/0", we_lo, oe_lo); end
        checks++; if (drv !== 3) begin errors++; $display("FAIL ld_write_drive: got %0d cycles expected 3", drv); end
        checks++; if (dout !== 16'h1234 || aa !== 20'h00040) begin errors++; $display("FAIL ld_write_data: got %h @%h expected 1234 @00040", dout, aa); end
        checks++; if (cpu_rdata !== 16'hBEEF || ld_rdata !== 16'h0) begin errors++; $display("FAIL write_keeps_rdata: got %h/%h expected BEEF/0", cpu_rdata, ld_rdata); end
        run_xact(1'b0, 1'b0, 20'h00040, 16'h0, lat, oe_lo, we_lo, drv, dout, aa, got);
        checks++; if (!got || cpu_rdata !== 16'h1234) begin errors++; $display("FAIL readback: got %h (ack=%b) expected 1234", cpu_rdata, got); end
    endtask

    task automatic test_back_to_back();
        int t, n;
        int at [2];
        t = 0; n = 0;
        cpu_we = 1'b0; cpu_addr = 20'h00040; cpu_req = 1'b1;
        for (int i = 0; i < 30 && n < 2; i++) begin
            tick();
            t++;
            if (cpu_ack) begin at[n] = t; n++; end
        end
        cpu_req = 1'b0;
        tick();
        checks++; if (n !== 2 || at[0] !== 4 || at[1] !== 9) begin errors++; $display("FAIL back_to_back: got %0d acks at %0d,%0d expected 2 at 4,9", n, at[0], at[1]); end
    endtask

    task automatic test_addr_hold();
        int bad;
        bit got;
        bad = 0; got = 1'b0;
        cpu_we = 1'b0; cpu_addr = 20'h00123; cpu_req = 1'b1;
        tick();
        tick();
        cpu_addr = 20'h00777; cpu_we = 1'b1; cpu_wdata = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (Mem_ADDR !== 20'h00123 || !Mem_WE) bad++;
            if (cpu_ack) begin got = 1'b1; break; end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        checks++; if (!got || bad !== 0) begin errors++; $display("FAIL addr_hold: got %0d bad cycles (ack=%b) expected 0", bad, got); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL addr_hold_data: got %h expected BEEF", cpu_rdata); end
    endtask

    task automatic test_arbitration();
        int n;
        bit ord [4];
        bit exp_ord [4];
`ifdef SRAM_ARB_RR_EN
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ord = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        n = 0;
        do_reset();
        cpu_we = 1'b0; cpu_addr = 20'h00123; ld_we = 1'b0; ld_addr = 20'h00040;
        cpu_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (cpu_ack) begin ord[n] = 1'b0; n++; end
            else if (ld_ack) begin ord[n] = 1'b1; n++; end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();
        checks++; if (n !== 4) begin errors++; $display("FAIL arb_count: got %0d grants expected 4", n); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (ord[k] !== exp_ord[k]) begin errors++; $display("FAIL arb_order[%0d]: got %0d expected %0d (0=cpu 1=ld)", k, ord[k], exp_ord[k]); end
        end
        for (int i = 0; i < 10 && !Mem_CE; i++) tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        cpu_we = 1'b1; cpu_addr = 20'h00055; cpu_wdata = 16'hAAAA; cpu_req = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (Mem_WE !== 1'b0) begin errors++; $display("FAIL mid_pre_we: got %b expected 0", Mem_WE); end
        Reset = 1'b1;
        cpu_req = 1'b0;
        tick();
        checks++; if (Mem_WE !== 1'b1 || Data_drive !== 1'b0 || Mem_CE !== 1'b1) begin errors++; $display("FAIL mid_reset_strobes: got WE=%b drive=%b CE=%b expected 1/0/1", Mem_WE, Data_drive, Mem_CE); end
        checks++; if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h0) begin errors++; $display("FAIL mid_reset_state: got ack=%b rdata=%h expected 0/0", cpu_ack, cpu_rdata); end
        Reset = 1'b0;
        cpu_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack || ld_ack || !Mem_CE) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL mid_reset_idle: got %0d active cycles expected 0", acks); end
    endtask

    task automatic test_wait_variants();
        int lat1, lat15, oe1, oe15;
        lat1 = 0; lat15 = 0; oe1 = 0; oe15 = 0;
        a1_req = 1'b1; a15_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!a1_oe) oe1++;
            if (!a15_oe) oe15++;
            if (a1_ack && lat1 == 0) begin lat1 = i; a1_req = 1'b0; end
            if (a15_ack && lat15 == 0) begin lat15 = i; a15_req = 1'b0; end
            if (lat1 != 0 && lat15 != 0) break;
        end
        a1_req = 1'b0; a15_req = 1'b0;
        tick();
        checks++; if (lat1 !== 3 || oe1 !== 1) begin errors++; $display("FAIL wait1: got latency %0d OE low %0d expected 3/1", lat1, oe1); end
        checks++; if (lat15 !== 17 || oe15 !== 15) begin errors++; $display("FAIL wait15: got latency %0d OE low %0d expected 17/15", lat15, oe15); end
        checks++; if (a1_rdata !== 16'hC0DE || a15_rdata !== 16'hC0DE) begin errors++; $display("FAIL wait_rdata: got %h/%h expected C0DE/C0DE", a1_rdata, a15_rdata); end
    endtask

    initial begin
        Reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        a1_req = 1'b0; a15_req = 1'b0; tie0 = 1'b0;
        tie_addr = 20'h00010; tie_data = 16'h0; aux_din = 16'hC0DE;
        test_reset();
        test_cpu_read();
        test_ld_write();
        test_back_to_back();
        test_addr_hold();
        test_arbitration();
        test_reset_mid();
        test_wait_variants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
